load_store_unit: RTL and testbench

Multi-cycle load/store sequencer between the CPU's MEM state and the word-wide data memory. The memory has a combinational 32-bit little-endian read, a synchronous write and no byte enables. This block turns byte, halfword and word accesses into aligned word transactions:

- loads are extracted with sign or zero extension;
- sub-word stores are done as read-modify-write;
- misaligned or illegal accesses are flagged without touching memory.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/lsu_lane.sv | 72 +++++++
 rtl/load_store_unit.sv | 100 ++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_e;

    // Reserved size is treated as a fault alongside real misalignment.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lo);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = lo[0];
            SZ_WORD: f = (lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request bus and word-memory port of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wData;
  logic              o_ready;
  logic              o_done;
  logic              o_fault;
  logic [31:0]       o_rData;
  logic              o_DMem_we;
  logic [ADDR_W-1:0] o_DMem_addr;
  logic [31:0]       o_DMem_wData;
  logic [31:0]       i_DMem_rData;

  modport master (
    output i_req, i_we, i_size, i_unsigned, i_addr, i_wData, i_DMem_rData,
    input  o_ready, o_done, o_fault, o_rData, o_DMem_we, o_DMem_addr, o_DMem_wData
  );

  modport slave (
    input  i_req, i_we, i_size, i_unsigned, i_addr, i_wData, i_DMem_rData,
    output o_ready, o_done, o_fault, o_rData, o_DMem_we, o_DMem_addr, o_DMem_wData
  );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extraction with sign/zero extension and
// sub-word store merge into the previously read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword from the read word.
  always_comb begin
    byte_s = 8'h00;
    case (lane)
      2'd0:    byte_s = rd_word[7:0];
      2'd1:    byte_s = rd_word[15:8];
      2'd2:    byte_s = rd_word[23:16];
      2'd3:    byte_s = rd_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = rd_word[31:16];
    end else begin
      half_s = rd_word[15:0];
    end
  end

  // Extend the selected lane; full words pass through unmodified.
  always_comb begin
    load_val = rd_word;
    case (size)
      SZ_BYTE: load_val = {{24{~is_unsigned & byte_s[7]}}, byte_s};
      SZ_HALF: load_val = {{16{~is_unsigned & half_s[15]}}, half_s};
      default: load_val = rd_word;
    endcase
  end

  // Replace only the addressed lane of the old word for sub-word stores.
  always_comb begin
    merge_word = st_data;
    case (size)
      SZ_BYTE: begin
        merge_word = old_word;
        case (lane)
          2'd0:    merge_word[7:0]   = st_data[7:0];
          2'd1:    merge_word[15:8]  = st_data[7:0];
          2'd2:    merge_word[23:16] = st_data[7:0];
          2'd3:    merge_word[31:24] = st_data[7:0];
          default: merge_word = old_word;
        endcase
      end
      SZ_HALF: begin
        merge_word = old_word;
        if (lane[1]) begin
          merge_word[31:16] = st_data[15:0];
        end else begin
          merge_word[15:0] = st_data[15:0];
        end
      end
      default: merge_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: turns byte/half/word accesses into
// aligned word transactions, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  lsu_state_e        state_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       old_r;
  logic [31:0]       rdata_r;
  logic              fault_r;

  logic [31:0]       load_val_s;
  logic [31:0]       merge_s;
  logic              mem_active_s;

  lsu_lane u_lane (
    .size        (size_r),
    .is_unsigned (uns_r),
    .lane        (addr_r[1:0]),
    .rd_word     (bus.i_DMem_rData),
    .old_word    (old_r),
    .st_data     (wdata_r),
    .load_val    (load_val_s),
    .merge_word  (merge_s)
  );

  // Sequencer state, latched request and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      size_r  <= SZ_BYTE;
      uns_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      old_r   <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_req) begin
            we_r    <= bus.i_we;
            size_r  <= bus.i_size;
            uns_r   <= bus.i_unsigned;
            addr_r  <= bus.i_addr;
            wdata_r <= bus.i_wData;
            if (access_fault(bus.i_size, bus.i_addr[1:0])) begin
              fault_r <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              fault_r <= 1'b0;
              if (bus.i_we && (bus.i_size == SZ_WORD)) begin
                state_r <= ST_WRITE;
              end else begin
                state_r <= ST_READ;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          old_r <= bus.i_DMem_rData;
          if (we_r) begin
            state_r <= ST_WRITE;
          end else begin
            rdata_r <= load_val_s;
            state_r <= ST_DONE;
          end
        end
        ST_WRITE: state_r <= ST_DONE;
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes are pure state decodes, so reset kills them at once.
  assign mem_active_s     = (state_r == ST_READ) || (state_r == ST_WRITE);
  assign bus.o_ready      = (state_r == ST_IDLE);
  assign bus.o_done       = (state_r == ST_DONE);
  assign bus.o_fault      = (state_r == ST_DONE) && fault_r;
  assign bus.o_rData      = rdata_r;
  assign bus.o_DMem_we    = (state_r == ST_WRITE);
  assign bus.o_DMem_addr  = mem_active_s ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign bus.o_DMem_wData = (state_r == ST_WRITE) ? merge_s : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  logic mem_init;
  logic [31:0] mem [0:15];
  int vec_cnt;
  int err_cnt;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.i_DMem_rData = mem[bus.o_DMem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
      mem[4] <= 32'h8899_AABB;
    end else if (bus.o_DMem_we) begin
      mem[bus.o_DMem_addr[5:2]] <= bus.o_DMem_wData;
    end
  end

  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int done_cyc, output int we_cyc, output int we_cnt,
                            output logic flt, output logic [31:0] we_addr,
                            output logic [31:0] we_data);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.i_req = 1'b1; bus.i_we = we; bus.i_size = sz; bus.i_unsigned = uns;
    bus.i_addr = a; bus.i_wData = wd;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    done_cyc = 0; we_cyc = 0; we_cnt = 0; flt = 1'b0; we_addr = 32'h0; we_data = 32'h0;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      if (bus.o_DMem_we) begin
        we_cyc = c; we_cnt++; we_addr = bus.o_DMem_addr; we_data = bus.o_DMem_wData;
      end
      if (bus.o_done) begin
        done_cyc = c; flt = bus.o_fault;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vec_cnt++;
    if ({bus.o_ready, bus.o_done, bus.o_fault, bus.o_DMem_we} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 1000", {bus.o_ready, bus.o_done, bus.o_fault, bus.o_DMem_we});
    end
    vec_cnt++;
    if ({bus.o_rData, bus.o_DMem_addr, bus.o_DMem_wData} !== 96'h0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h %h %h want 0", bus.o_rData, bus.o_DMem_addr, bus.o_DMem_wData);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz [4] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_WORD};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] ex [4] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h8899_AABB};
    int dc, wc, wn; logic f; logic [31:0] wa, wdv;
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, sz[i], un[i], ad[i], 32'h0, dc, wc, wn, f, wa, wdv);
      vec_cnt++;
      if ({dc, wn, 31'd0, f} !== {32'd2, 32'd0, 32'd0}) begin
        err_cnt++;
        $display("FAIL load%0d_timing: got done=%0d we=%0d fault=%b want done=2 we=0 fault=0", i, dc, wn, f);
      end
      vec_cnt++;
      if (bus.o_rData !== ex[i]) begin
        err_cnt++;
        $display("FAIL load%0d_rdata: got %h want %h", i, bus.o_rData, ex[i]);
      end
    end
  endtask

  task automatic test_sb();
    int dc, wc, wn; logic f; logic [31:0] wa, wdv;
    run_access(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_5677, dc, wc, wn, f, wa, wdv);
    vec_cnt++;
    if ({dc, wc, wn} !== {32'd3, 32'd2, 32'd1}) begin
      err_cnt++;
      $display("FAIL sb_timing: got done=%0d wecyc=%0d wecnt=%0d want 3 2 1", dc, wc, wn);
    end
    vec_cnt++;
    if ({wa, wdv} !== {32'h10, 32'h8899_77BB}) begin
      err_cnt++;
      $display("FAIL sb_write: got %h %h want 00000010 889977bb", wa, wdv);
    end
    run_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, dc, wc, wn, f, wa, wdv);
    vec_cnt++;
    if (bus.o_rData !== 32'h8899_77BB) begin
      err_cnt++;
      $display("FAIL sb_readback: got %h want 889977bb", bus.o_rData);
    end
  endtask

  task automatic test_sw_sh();
    int dc, wc, wn; logic f; logic [31:0] wa, wdv;
    run_access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, dc, wc, wn, f, wa, wdv);
    vec_cnt++;
    if ({dc, wc, wn} !== {32'd2, 32'd1, 32'd1} || wdv !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL sw: got done=%0d wecyc=%0d wecnt=%0d data=%h want 2 1 1 deadbeef", dc, wc, wn, wdv);
    end
    run_access(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_CAFE, dc, wc, wn, f, wa, wdv);
    vec_cnt++;
    if (dc !== 3 || mem[4] !== 32'hCAFE_BEEF) begin
      err_cnt++;
      $display("FAIL sh: got done=%0d mem=%h want 3 cafebeef", dc, mem[4]);
    end
    run_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, dc, wc, wn, f, wa, wdv);
    vec_cnt++;
    if (bus.o_rData !== 32'hCAFE_BEEF) begin
      err_cnt++;
      $display("FAIL sh_readback: got %h want cafebeef", bus.o_rData);
    end
  endtask

  task automatic test_faults();
    logic        we [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [3] = '{SZ_HALF, SZ_WORD, SZ_RSVD};
    logic [31:0] ad [3] = '{32'h11, 32'h12, 32'h10};
    int dc, wc, wn; logic f; logic [31:0] wa, wdv;
    for (int i = 0; i < 3; i++) begin
      run_access(we[i], sz[i], 1'b0, ad[i], 32'h5555_5555, dc, wc, wn, f, wa, wdv);
      vec_cnt++;
      if (dc !== 1 || f !== 1'b1 || wn !== 0) begin
        err_cnt++;
        $display("FAIL fault%0d: got done=%0d fault=%b we=%0d want 1 1 0", i, dc, f, wn);
      end
      vec_cnt++;
      if (mem[4] !== 32'hCAFE_BEEF || bus.o_rData !== 32'hCAFE_BEEF) begin
        err_cnt++;
        $display("FAIL fault%0d_state: got mem=%h rdata=%h want cafebeef cafebeef", i, mem[4], bus.o_rData);
      end
    end
  endtask

  task automatic test_reset_in_write();
    int dones;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_size = SZ_BYTE; bus.i_unsigned = 1'b0;
    bus.i_addr = 32'h10; bus.i_wData = 32'h0000_00FF;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.o_DMem_we !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstw_precond: got we=%b want 1", bus.o_DMem_we);
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (bus.o_DMem_we !== 1'b0 || bus.o_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstw_async: got we=%b ready=%b want 0 1", bus.o_DMem_we, bus.o_ready);
    end
    dones = 0;
    @(posedge clk); #1;
    if (bus.o_done) dones++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.o_done) dones++;
    end
    vec_cnt++;
    if (dones !== 0 || bus.o_ready !== 1'b1 || mem[4] !== 32'hCAFE_BEEF) begin
      err_cnt++;
      $display("FAIL rstw_after: got dones=%0d ready=%b mem=%h want 0 1 cafebeef", dones, bus.o_ready, mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  rdy;
    logic [5:0]  dn;
    logic [31:0] first_r;
    logic [31:0] second_r;
    first_r = 32'h0; second_r = 32'h0; rdy = 6'b0; dn = 6'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_size = SZ_BYTE; bus.i_unsigned = 1'b0;
    bus.i_addr = 32'h13; bus.i_wData = 32'h0;
    @(posedge clk); #1;
    bus.i_size = SZ_WORD; bus.i_addr = 32'h10;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) bus.i_req = 1'b0;
      rdy[c-1] = bus.o_ready;
      dn[c-1]  = bus.o_done;
      if (c == 2) first_r = bus.o_rData;
      if (c == 5) second_r = bus.o_rData;
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0;
    vec_cnt++;
    if (rdy !== 6'b100100 || dn !== 6'b010010) begin
      err_cnt++;
      $display("FAIL b2b_timing: got ready=%b done=%b want 100100 010010", rdy, dn);
    end
    vec_cnt++;
    if (first_r !== 32'hFFFF_FFCA || second_r !== 32'hCAFE_BEEF) begin
      err_cnt++;
      $display("FAIL b2b_data: got %h %h want ffffffca cafebeef", first_r, second_r);
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst = 1'b1; mem_init = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = SZ_BYTE; bus.i_unsigned = 1'b0;
    bus.i_addr = 32'h0; bus.i_wData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    test_loads();
    test_sb();
    test_sw_sh();
    test_faults();
    test_reset_in_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
